// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the 5-stage MIPS pipeline controller: opcode and
// funct constants, the hazard FSM state encoding, and small decode helpers
// that report which register sources an ID-stage instruction reads.
// ----------------------------------------------------------------------------
package pipeline_pkg;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;  // REGIMM group (bltz/bgez/...)
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STALL     = 2'd1,
        ST_IRQ_ENTER = 2'd2
    } hz_state_e;

    // Reads rs: everything except j/jal/lui and the immediate shifts.
    // The all-zero word (nop) reads nothing.
    function automatic logic uses_rs(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        if (instr == 32'd0)
            return 1'b0;
        if (op == OP_J || op == OP_JAL || op == OP_LUI)
            return 1'b0;
        if (op == OP_RTYPE && (fn == F_SLL || fn == F_SRL || fn == F_SRA))
            return 1'b0;
        return 1'b1;
    endfunction

    // Reads rt: R-type, beq/bne compare operand, sw store data.
    function automatic logic uses_rt(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        if (instr == 32'd0)
            return 1'b0;
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    // Branches and register jumps whose operands are consumed in ID.
    function automatic logic id_resolved(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        return (op == OP_BLTZ) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BLEZ) || (op == OP_BGTZ) ||
               (op == OP_RTYPE && (fn == F_JR || fn == F_JALR));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the datapath/Control and the hazard controller.
//   Inputs to controller : ID_instruction, ID_PC31, ID_BranchTaken, ID_Jump,
//                          EX_RegWr, EX_MemRd, EX_WrReg,
//                          MEM_RegWr, MEM_MemRd, MEM_WrReg, IRQ
//   Outputs from ctrl    : PC_Wr, IFID_Wr, IFID_flush, IDEX_flush,
//                          ForwardC, ForwardD, IRQ_take, stall_cnt
// modport slave  : the controller side.
// modport master : the pipeline side that drives status and consumes controls.
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;

    logic [31:0] ID_instruction;
    logic        ID_PC31;
    logic        ID_BranchTaken;
    logic        ID_Jump;
    logic        EX_RegWr;
    logic        EX_MemRd;
    logic [4:0]  EX_WrReg;
    logic        MEM_RegWr;
    logic        MEM_MemRd;
    logic [4:0]  MEM_WrReg;
    logic        IRQ;

    logic        PC_Wr;
    logic        IFID_Wr;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        ForwardC;
    logic        ForwardD;
    logic        IRQ_take;
    logic [1:0]  stall_cnt;

    modport slave (
        input  ID_instruction, ID_PC31, ID_BranchTaken, ID_Jump,
               EX_RegWr, EX_MemRd, EX_WrReg,
               MEM_RegWr, MEM_MemRd, MEM_WrReg, IRQ,
        output PC_Wr, IFID_Wr, IFID_flush, IDEX_flush,
               ForwardC, ForwardD, IRQ_take, stall_cnt
    );

    modport master (
        output ID_instruction, ID_PC31, ID_BranchTaken, ID_Jump,
               EX_RegWr, EX_MemRd, EX_WrReg,
               MEM_RegWr, MEM_MemRd, MEM_WrReg, IRQ,
        input  PC_Wr, IFID_Wr, IFID_flush, IDEX_flush,
               ForwardC, ForwardD, IRQ_take, stall_cnt
    );

endinterface

// File: rtl/pipeline_irq_sync.sv
// ----------------------------------------------------------------------------
// pipeline_irq_sync
// Brings the asynchronous level IRQ into the clk domain through STAGES flops
// and remembers it in a pending flag until the controller accepts it.
//   clk     in  core clock
//   reset   in  synchronous, active-high; clears chain and pending
//   irq     in  asynchronous level interrupt request
//   clear   in  interrupt accepted this cycle; drops pending
//   pending out interrupt waiting for a safe point
// STAGES must be at least 1.
// ----------------------------------------------------------------------------
module pipeline_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic clear,
    output logic pending
);

    logic [STAGES-1:0] chain;

    // NOTE: every flop in this design is written with <= so all registers
    // update from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain   <= '0;
            pending <= 1'b0;
        end else begin
            chain[0] <= irq;
            for (int i = 1; i < STAGES; i++)
                chain[i] <= chain[i-1];
            // Acceptance wins over a still-high request; a level IRQ that is
            // still asserted simply re-arms pending on the next edge.
            if (clear)
                pending <= 1'b0;
            else if (chain[STAGES-1])
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard/flush/interrupt controller for the 5-stage MIPS core.
// Decodes the ID instruction's sources, compares them with the EX and MEM
// destinations, sequences multi-cycle stalls, selects ID-stage forwarding
// from MEM, flushes on taken branches/jumps and inserts interrupt entry at
// a safe point.
//   clk    in  core clock
//   reset  in  synchronous, active-high
//   bus    slave modport of pipeline_hazard_ctrl_if (status in, controls out)
// stall_cnt reports the stall cycles still owed after the current one.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2,
    parameter int LOAD_BR_STALLS  = 2
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] LD_BR_N = 2'(LOAD_BR_STALLS);

    hz_state_e  state, state_d;
    logic [1:0] cnt, cnt_d;
    logic [1:0] n_haz;
    logic       irq_pending;
    logic       take_ok;

    logic [4:0] rs, rt;
    logic       use_rs, use_rt, id_res;
    logic       rs_ex, rt_ex, rs_mem, rt_mem;
    logic       ex_load, ex_alu, mem_load;

    // ------------------------------------------------------------------
    // Source decode and register comparison ($0 never matches)
    // ------------------------------------------------------------------
    assign rs     = bus.ID_instruction[25:21];
    assign rt     = bus.ID_instruction[20:16];
    assign use_rs = uses_rs(bus.ID_instruction);
    assign use_rt = uses_rt(bus.ID_instruction);
    assign id_res = id_resolved(bus.ID_instruction);

    assign rs_ex  = use_rs && bus.EX_RegWr  && (bus.EX_WrReg  == rs) && (rs != 5'd0);
    assign rt_ex  = use_rt && bus.EX_RegWr  && (bus.EX_WrReg  == rt) && (rt != 5'd0);
    assign rs_mem = use_rs && bus.MEM_RegWr && (bus.MEM_WrReg == rs) && (rs != 5'd0);
    assign rt_mem = use_rt && bus.MEM_RegWr && (bus.MEM_WrReg == rt) && (rt != 5'd0);

    assign ex_load  = bus.EX_MemRd;
    assign ex_alu   = !bus.EX_MemRd;
    assign mem_load = bus.MEM_MemRd;

    // Number of bubbles the ID instruction needs before its operands exist.
    // A load feeding an ID-resolved consumer waits until its data reaches WB.
    always_comb begin
        if (ex_load && (rs_ex || rt_ex))
            n_haz = id_res ? LD_BR_N : 2'd1;
        else if (ex_alu && id_res && (rs_ex || rt_ex))
            n_haz = 2'd1;
        else if (mem_load && id_res && (rs_mem || rt_mem))
            n_haz = 2'd1;
        else
            n_haz = 2'd0;
    end

    assign take_ok = irq_pending && !bus.ID_PC31 &&
                     !bus.ID_BranchTaken && !bus.ID_Jump;

    // ------------------------------------------------------------------
    // Control outputs and next state
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned; that is what keeps this block latch-free.
    always_comb begin
        bus.PC_Wr      = 1'b1;
        bus.IFID_Wr    = 1'b1;
        bus.IFID_flush = 1'b0;
        bus.IDEX_flush = 1'b0;
        bus.IRQ_take   = 1'b0;
        state_d        = state;
        cnt_d          = cnt;

        unique case (state)
            ST_RUN: begin
                if (n_haz != 2'd0) begin
                    bus.PC_Wr      = 1'b0;
                    bus.IFID_Wr    = 1'b0;
                    bus.IDEX_flush = 1'b1;
                    if (n_haz > 2'd1) begin
                        state_d = ST_STALL;
                        cnt_d   = n_haz - 2'd1;
                    end
                end else if (take_ok) begin
                    bus.IRQ_take = 1'b1;
                    state_d      = ST_IRQ_ENTER;
                end else if (bus.ID_BranchTaken || bus.ID_Jump) begin
                    bus.IFID_flush = 1'b1;
                end
            end
            ST_STALL: begin
                // Detection and branch inputs are ignored until the
                // committed stall sequence has drained.
                bus.PC_Wr      = 1'b0;
                bus.IFID_Wr    = 1'b0;
                bus.IDEX_flush = 1'b1;
                cnt_d          = cnt - 2'd1;
                if (cnt == 2'd1)
                    state_d = ST_RUN;
            end
            ST_IRQ_ENTER: begin
                bus.IFID_flush = 1'b1;
                state_d        = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase

        // Reset overrides everything so an aborted stall or interrupt entry
        // leaves no flush or stall visible in the reset cycle.
        if (reset) begin
            bus.PC_Wr      = 1'b1;
            bus.IFID_Wr    = 1'b1;
            bus.IFID_flush = 1'b0;
            bus.IDEX_flush = 1'b0;
            bus.IRQ_take   = 1'b0;
            state_d        = ST_RUN;
            cnt_d          = 2'd0;
        end
    end

    assign bus.stall_cnt = cnt_d;

    // Forwarding from MEM is only meaningful for ALU results in RUN.
    assign bus.ForwardC = rs_mem && !bus.MEM_MemRd && (state == ST_RUN) && !reset;
    assign bus.ForwardD = rt_mem && !bus.MEM_MemRd && (state == ST_RUN) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt synchronizer and pending flag
    // ------------------------------------------------------------------
    pipeline_irq_sync #(
        .STAGES (IRQ_SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .reset   (reset),
        .irq     (bus.IRQ),
        .clear   (bus.IRQ_take),
        .pending (irq_pending)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Each step drives the pipeline
// status for one cycle, queues the control word the controller should
// produce, and compares it against the outputs mid-cycle.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    typedef struct packed {
        logic       pc_wr;
        logic       ifid_wr;
        logic       ifid_flush;
        logic       idex_flush;
        logic       fwd_c;
        logic       fwd_d;
        logic       irq_take;
        logic [1:0] stall_cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl #(
        .IRQ_SYNC_STAGES (2),
        .LOAD_BR_STALLS  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- expected control words ----------------
    function automatic exp_t e_run(input logic fc, input logic fd);
        return '{pc_wr:1'b1, ifid_wr:1'b1, ifid_flush:1'b0, idex_flush:1'b0,
                 fwd_c:fc, fwd_d:fd, irq_take:1'b0, stall_cnt:2'd0};
    endfunction

    function automatic exp_t e_stall(input logic [1:0] remaining);
        return '{pc_wr:1'b0, ifid_wr:1'b0, ifid_flush:1'b0, idex_flush:1'b1,
                 fwd_c:1'b0, fwd_d:1'b0, irq_take:1'b0, stall_cnt:remaining};
    endfunction

    function automatic exp_t e_flush();
        return '{pc_wr:1'b1, ifid_wr:1'b1, ifid_flush:1'b1, idex_flush:1'b0,
                 fwd_c:1'b0, fwd_d:1'b0, irq_take:1'b0, stall_cnt:2'd0};
    endfunction

    function automatic exp_t e_take();
        return '{pc_wr:1'b1, ifid_wr:1'b1, ifid_flush:1'b0, idex_flush:1'b0,
                 fwd_c:1'b0, fwd_d:1'b0, irq_take:1'b1, stall_cnt:2'd0};
    endfunction

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0010};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_ex(input logic wr, input logic rd, input logic [4:0] dst);
        bus.EX_RegWr = wr;
        bus.EX_MemRd = rd;
        bus.EX_WrReg = dst;
    endtask

    task automatic set_mem(input logic wr, input logic rd, input logic [4:0] dst);
        bus.MEM_RegWr = wr;
        bus.MEM_MemRd = rd;
        bus.MEM_WrReg = dst;
    endtask

    task automatic bubbles();
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b0, 1'b0, 5'd0);
        bus.ID_BranchTaken = 1'b0;
        bus.ID_Jump        = 1'b0;
        bus.ID_instruction = 32'd0;
    endtask

    task automatic check_out();
        exp_t  e;
        exp_t  got;
        string tag;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        got = '{pc_wr:bus.PC_Wr, ifid_wr:bus.IFID_Wr, ifid_flush:bus.IFID_flush,
                idex_flush:bus.IDEX_flush, fwd_c:bus.ForwardC, fwd_d:bus.ForwardD,
                irq_take:bus.IRQ_take, stall_cnt:bus.stall_cnt};
        compared++;
        assert (got === e) else begin
            mismatched++;
            $error("FAIL %s: observed pc/ifid/ifidfl/idexfl/fc/fd/take/cnt=%b expected %b",
                   tag, got, e);
        end
    endtask

    // Inputs are already applied (1 time unit after the edge); sample
    // mid-cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #4;
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.ID_PC31    = 1'b0;
        bus.IRQ        = 1'b0;
        bubbles();

        @(posedge clk);
        #1;
        step("reset_hold", e_run(1'b0, 1'b0));
        reset = 1'b0;
        step("idle", e_run(1'b0, 1'b0));

        // lw $8 in EX, add $9,$8,$10 in ID: one bubble
        set_ex(1'b1, 1'b1, 5'd8);
        bus.ID_instruction = rtype(5'd8, 5'd10, 5'd9, 6'h20);
        step("lw_add_stall", e_stall(2'd0));
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd8);
        step("lw_add_resume", e_run(1'b0, 1'b0));

        // lw $8 in EX, beq $8,$9 in ID: two bubbles
        bubbles();
        set_ex(1'b1, 1'b1, 5'd8);
        bus.ID_instruction = itype(OP_BEQ, 5'd8, 5'd9);
        step("lw_beq_stall1", e_stall(2'd1));
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd8);
        bus.ID_BranchTaken = 1'b1;
        step("lw_beq_stall2", e_stall(2'd0));
        set_mem(1'b0, 1'b0, 5'd0);
        step("lw_beq_taken", e_flush());

        // add $8 in EX, bne $8,$0 in ID: one bubble then forward from MEM
        bubbles();
        set_ex(1'b1, 1'b0, 5'd8);
        bus.ID_instruction = itype(OP_BNE, 5'd8, 5'd0);
        step("alu_bne_stall", e_stall(2'd0));
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b0, 5'd8);
        step("alu_bne_fwdc", e_run(1'b1, 1'b0));
        bus.ID_instruction = rtype(5'd10, 5'd8, 5'd9, 6'h20);
        step("add_fwdd", e_run(1'b0, 1'b1));
        set_ex(1'b1, 1'b0, 5'd8);
        bus.ID_instruction = rtype(5'd8, 5'd8, 5'd9, 6'h20);
        step("alu_ex_nonbranch", e_run(1'b1, 1'b1));

        // Register 0 never creates a hazard
        bubbles();
        set_ex(1'b1, 1'b1, 5'd0);
        bus.ID_instruction = itype(OP_BEQ, 5'd0, 5'd0);
        bus.ID_BranchTaken = 1'b1;
        step("lw_r0_beq", e_flush());

        // lw $8 in EX, jr $8: two bubbles, then jump flush
        bubbles();
        set_ex(1'b1, 1'b1, 5'd8);
        bus.ID_instruction = rtype(5'd8, 5'd0, 5'd0, F_JR);
        bus.ID_Jump = 1'b1;
        step("lw_jr_stall1", e_stall(2'd1));
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd8);
        step("lw_jr_stall2", e_stall(2'd0));
        set_mem(1'b0, 1'b0, 5'd0);
        step("lw_jr_flush", e_flush());

        // j and lui carry register-looking fields but read no sources
        bubbles();
        set_ex(1'b1, 1'b1, 5'd8);
        bus.ID_instruction = itype(OP_J, 5'd8, 5'd8);
        bus.ID_Jump = 1'b1;
        step("j_no_src", e_flush());
        bus.ID_Jump = 1'b0;
        bus.ID_instruction = itype(OP_LUI, 5'd8, 5'd8);
        step("lui_no_src", e_run(1'b0, 1'b0));
        bus.ID_instruction = rtype(5'd0, 5'd8, 5'd9, F_SLL);
        step("sll_rt_stall", e_stall(2'd0));
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd8);
        step("mem_load_nonbranch", e_run(1'b0, 1'b0));
        bus.ID_instruction = itype(OP_BEQ, 5'd8, 5'd9);
        step("mem_load_beq", e_stall(2'd0));

        // IRQ masked by kernel mode, then taken at a safe point
        bubbles();
        bus.ID_PC31 = 1'b1;
        bus.IRQ     = 1'b1;
        for (int i = 0; i < 5; i++)
            step("irq_masked", e_run(1'b0, 1'b0));
        bus.IRQ = 1'b0;
        for (int i = 0; i < 3; i++)
            step("irq_masked_held", e_run(1'b0, 1'b0));
        bus.ID_PC31        = 1'b0;
        bus.ID_BranchTaken = 1'b1;
        step("branch_blocks_take", e_flush());
        bus.ID_BranchTaken = 1'b0;
        set_ex(1'b1, 1'b1, 5'd8);
        bus.ID_instruction = rtype(5'd8, 5'd10, 5'd9, 6'h20);
        step("stall_over_take", e_stall(2'd0));
        bubbles();
        step("irq_take", e_take());
        set_mem(1'b1, 1'b0, 5'd8);
        bus.ID_instruction = rtype(5'd8, 5'd10, 5'd9, 6'h20);
        step("irq_enter", e_flush());
        step("irq_cleared", e_run(1'b1, 1'b0));
        bubbles();
        step("irq_cleared_idle", e_run(1'b0, 1'b0));

        // Reset in the middle of a two-cycle stall with an interrupt pending
        bus.ID_PC31 = 1'b1;
        bus.IRQ     = 1'b1;
        for (int i = 0; i < 4; i++)
            step("irq_arm", e_run(1'b0, 1'b0));
        bus.IRQ = 1'b0;
        for (int i = 0; i < 3; i++)
            step("irq_arm_held", e_run(1'b0, 1'b0));
        set_ex(1'b1, 1'b1, 5'd8);
        bus.ID_instruction = itype(OP_BEQ, 5'd8, 5'd9);
        step("pre_reset_stall", e_stall(2'd1));
        reset = 1'b1;
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd8);
        step("reset_in_stall", e_run(1'b0, 1'b0));
        reset = 1'b0;
        bubbles();
        bus.ID_PC31 = 1'b0;
        step("after_reset", e_run(1'b0, 1'b0));
        step("after_reset_no_irq", e_run(1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
